nec_ir_receiver: RTL and testbench

- Fully synchronous, parametrised NEC-protocol IR frame receiver.
- Samples the demodulated IR line in the system clock domain, times mark and space durations with a prescaled tick, and classifies each frame as data, repeat or error.
- Shifts data bits into a SIGNAL_WIDTH code register, runs a checksum check, and flags results with single-cycle strobes for downstream decode and seven-segment logic.
- Adds repeat-frame detection, timeout recovery and an error strobe; uses no derived or data-driven clocks.

---
 rtl/ir_pkg.sv | 35 +++
 rtl/ir_tick_gen.sv | 33 +++
 rtl/nec_ir_receiver.sv | 168 ++++++++++++++++
 tb/tb_nec_ir_receiver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types, NEC timing defaults and checksum helper for the NEC IR receiver.
// Optional glitch filter in the top is enabled by defining IR_GLITCH_FILTER_EN.
package ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        RPT_MARK
    } ir_state_e;

    localparam int NEC_LEAD_MARK_MIN       = 8000;
    localparam int NEC_LEAD_SPACE_DATA_MIN = 3500;
    localparam int NEC_LEAD_SPACE_RPT_MIN  = 1800;
    localparam int NEC_BIT_ONE_MIN         = 1100;
    localparam int NEC_TIMEOUT_TICKS       = 12000;

    // Widest code the checksum helper accepts; narrower codes are zero-extended.
    localparam int CHK_MAX_W = 128;

    // Every 16-bit half must carry a byte followed by its bitwise complement.
    function automatic logic checksum_ok(input logic [CHK_MAX_W-1:0] code, input int width);
        logic ok;
        ok = 1'b1;
        for (int h = 0; h < CHK_MAX_W / 16; h++) begin
            if (h < width / 16 && code[h*16+8 +: 8] != ~code[h*16 +: 8])
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Sample-tick prescaler: one-cycle o_tick pulse every CLK_DIV system clocks.
// Part of nec_ir_receiver (optional IR_GLITCH_FILTER_EN lives in the top).
module ir_tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_q;
    logic          tick_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            div_q  <= div_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame receiver: synchroniser, tick-timed FSM, checksum, strobes.
// Define IR_GLITCH_FILTER_EN to insert a 3-tap majority filter before edge detection.
module nec_ir_receiver
    import ir_pkg::*;
#(
    parameter int CLK_DIV             = 50,
    parameter int SIGNAL_WIDTH        = 32,
    parameter int CNT_W               = 16,
    parameter int LEAD_MARK_MIN       = NEC_LEAD_MARK_MIN,
    parameter int LEAD_SPACE_DATA_MIN = NEC_LEAD_SPACE_DATA_MIN,
    parameter int LEAD_SPACE_RPT_MIN  = NEC_LEAD_SPACE_RPT_MIN,
    parameter int BIT_ONE_MIN         = NEC_BIT_ONE_MIN,
    parameter int TIMEOUT_TICKS       = NEC_TIMEOUT_TICKS
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_ir_signal,
    output logic [SIGNAL_WIDTH-1:0] o_code,
    output logic                    o_valid,
    output logic                    o_checksum_valid,
    output logic                    o_repeat,
    output logic                    o_error
);

    localparam int BCW = $clog2(SIGNAL_WIDTH + 1);
    localparam logic [BCW-1:0]   BIT_LAST    = BCW'(SIGNAL_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] T_LEAD_MARK = CNT_W'(LEAD_MARK_MIN);
    localparam logic [CNT_W-1:0] T_DATA      = CNT_W'(LEAD_SPACE_DATA_MIN);
    localparam logic [CNT_W-1:0] T_RPT       = CNT_W'(LEAD_SPACE_RPT_MIN);
    localparam logic [CNT_W-1:0] T_ONE       = CNT_W'(BIT_ONE_MIN);
    localparam logic [CNT_W-1:0] T_TIMEOUT   = CNT_W'(TIMEOUT_TICKS);

    logic tick;

    ir_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .o_tick (tick)
    );

    // Synchroniser resets to the idle-high level so reset release never looks like a mark.
    logic sync1_q, sync2_q, line, line_prev_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_ir_signal;
            sync2_q <= sync1_q;
        end
    end

`ifdef IR_GLITCH_FILTER_EN
    logic [1:0] taps_q;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            taps_q <= 2'b11;
        else if (tick)
            taps_q <= {taps_q[0], sync2_q};
    end

    assign line = (sync2_q & taps_q[0]) | (sync2_q & taps_q[1]) | (taps_q[0] & taps_q[1]);
`else
    assign line = sync2_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset)
            line_prev_q <= 1'b1;
        else if (tick)
            line_prev_q <= line;
    end

    logic fall, rise;
    assign fall = tick & line_prev_q & ~line;
    assign rise = tick & ~line_prev_q & line;

    ir_state_e               state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [BCW-1:0]          bitcnt_q;
    logic [SIGNAL_WIDTH-1:0] shift_q, code_q;
    logic                    chk_q, valid_q, repeat_q, error_q, have_code_q;
    logic                    abort;

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        abort = 1'b0;
        if (tick && state_q != IDLE) begin
            if (!rise && !fall)
                abort = (cnt_q >= T_TIMEOUT);
            else if (state_q == LEAD_MARK)
                abort = (cnt_q < T_LEAD_MARK);
            else if (state_q == LEAD_SPACE)
                abort = (cnt_q < T_RPT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            code_q      <= '0;
            chk_q       <= 1'b0;
            valid_q     <= 1'b0;
            repeat_q    <= 1'b0;
            error_q     <= 1'b0;
            have_code_q <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            repeat_q <= 1'b0;
            error_q  <= 1'b0;
            if (tick) begin
                if (cnt_q != CNT_MAX)
                    cnt_q <= cnt_q + 1'b1;
                if (rise || fall || state_q == IDLE)
                    cnt_q <= '0;
                if (abort) begin
                    error_q <= 1'b1;
                    shift_q <= '0;
                    state_q <= IDLE;
                end else begin
                    unique case (state_q)
                        IDLE:       if (fall) state_q <= LEAD_MARK;
                        LEAD_MARK:  if (rise) state_q <= LEAD_SPACE;
                        LEAD_SPACE: if (fall) begin
                            if (cnt_q >= T_DATA) begin
                                bitcnt_q <= '0;
                                state_q  <= BIT_MARK;
                            end else begin
                                state_q  <= RPT_MARK;
                            end
                        end
                        BIT_MARK:   if (rise) state_q <= BIT_SPACE;
                        BIT_SPACE:  if (fall) begin
                            shift_q  <= {cnt_q >= T_ONE, shift_q[SIGNAL_WIDTH-1:1]};
                            bitcnt_q <= bitcnt_q + 1'b1;
                            state_q  <= (bitcnt_q == BIT_LAST) ? STOP_MARK : BIT_MARK;
                        end
                        STOP_MARK:  if (rise) begin
                            code_q      <= shift_q;
                            chk_q       <= checksum_ok(CHK_MAX_W'(shift_q), SIGNAL_WIDTH);
                            valid_q     <= 1'b1;
                            have_code_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                        RPT_MARK:   if (rise) begin
                            repeat_q <= have_code_q;
                            state_q  <= IDLE;
                        end
                        default:    state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign o_code           = code_q;
    assign o_valid          = valid_q;
    assign o_checksum_valid = chk_q;
    assign o_repeat         = repeat_q;
    assign o_error          = error_q;

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Scoreboard bench for nec_ir_receiver at CLK_DIV=1 with NEC timings scaled by 1/10.
// Also builds with IR_GLITCH_FILTER_EN defined (glitch step expectation changes).
module tb_nec_ir_receiver;

    localparam int SW = 32;
    localparam logic [2:0] EV_VALID  = 3'b001;
    localparam logic [2:0] EV_REPEAT = 3'b010;
    localparam logic [2:0] EV_ERROR  = 3'b100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ir  = 1'b1;
    logic [SW-1:0] code;
    logic          valid, chk, rpt, err;

    always #5 clk = ~clk;

    nec_ir_receiver #(
        .CLK_DIV            (1),
        .SIGNAL_WIDTH       (SW),
        .CNT_W              (16),
        .LEAD_MARK_MIN      (800),
        .LEAD_SPACE_DATA_MIN(350),
        .LEAD_SPACE_RPT_MIN (180),
        .BIT_ONE_MIN        (110),
        .TIMEOUT_TICKS      (1200)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_ir_signal     (ir),
        .o_code          (code),
        .o_valid         (valid),
        .o_checksum_valid(chk),
        .o_repeat        (rpt),
        .o_error         (err)
    );

    typedef struct packed {
        logic [2:0]    kind;
        logic [SW-1:0] code;
        logic          chk;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int unsigned   cyc = 0;
    int unsigned   err_cyc = 0;
    int unsigned   t_hi = 0;
    logic [SW-1:0] m_code = '0;
    logic          m_chk = 1'b0;
    logic          m_have = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic nec_chk(input logic [SW-1:0] c);
        return (c[15:8] == ~c[7:0]) && (c[31:24] == ~c[23:16]);
    endfunction

    task automatic push(input logic [2:0] kind);
        exp_t e;
        e.kind = kind;
        e.code = m_code;
        e.chk  = m_chk;
        sb.push_back(e);
    endtask

    task automatic expect_valid(input logic [SW-1:0] c);
        m_code = c;
        m_chk  = nec_chk(c);
        m_have = 1'b1;
        push(EV_VALID);
    endtask

    task automatic expect_repeat();
        if (m_have) push(EV_REPEAT);
    endtask

    task automatic model_reset();
        m_code = '0;
        m_chk  = 1'b0;
        m_have = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (valid || rpt || err)) begin
                check("one_strobe", 64'($countones({err, rpt, valid})), 64'd1);
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {61'd0, err, rpt, valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("kind", {61'd0, err, rpt, valid}, {61'd0, e.kind});
                    check("code", {32'd0, code}, {32'd0, e.code});
                    check("chk", {63'd0, chk}, {63'd0, e.chk});
                    if (err) err_cyc = cyc;
                end
            end
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        @(negedge clk);
        ir = lvl;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_leader(input int space);
        drive(1'b0, 900);
        drive(1'b1, space);
    endtask

    task automatic send_bits(input logic [SW-1:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 56);
            drive(1'b1, c[i] ? 169 : 56);
        end
    endtask

    task automatic send_frame(input logic [SW-1:0] c);
        send_leader(450);
        send_bits(c, SW);
        drive(1'b0, 56);
        drive(1'b1, 100);
    endtask

    task automatic send_repeat();
        send_leader(225);
        drive(1'b0, 56);
        drive(1'b1, 100);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_code"}, {32'd0, code}, 64'd0);
        check({tag, "_valid"}, {63'd0, valid}, 64'd0);
        check({tag, "_chk"}, {63'd0, chk}, 64'd0);
        check({tag, "_repeat"}, {63'd0, rpt}, 64'd0);
        check({tag, "_error"}, {63'd0, err}, 64'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        model_reset();
        drive(1'b1, 20);

        // Repeat with no stored code must stay silent.
        expect_repeat();
        send_repeat();
        drain("repeat_no_code");

        expect_valid(32'hF708FB04);
        send_frame(32'hF708FB04);
        drain("frame_good");

        expect_valid(32'hF708FB05);
        send_frame(32'hF708FB05);
        drain("frame_badsum");

        expect_repeat();
        send_repeat();
        drain("repeat_after_code");

        push(EV_ERROR);
        drive(1'b0, 500);
        drive(1'b1, 100);
        drain("short_leader");

        // Line stuck high inside a bit space.
        push(EV_ERROR);
        send_leader(450);
        send_bits(32'hF708FB04, 10);
        drive(1'b0, 56);
        @(negedge clk);
        ir   = 1'b1;
        t_hi = cyc;
        repeat (1299) @(negedge clk);
        drain("timeout");
        check("timeout_delay", {63'd0, (err_cyc - t_hi) inside {[1201:1208]}}, 64'd1);

        expect_valid(32'h00FF807F);
        send_frame(32'h00FF807F);
        drain("frame_after_timeout");

`ifndef IR_GLITCH_FILTER_EN
        push(EV_ERROR);
`endif
        drive(1'b0, 1);
        drive(1'b1, 50);
        drain("idle_glitch");

        send_leader(450);
        send_bits(32'hF708FB04, 20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        rst = 1'b0;
        model_reset();
        drive(1'b1, 50);

        expect_repeat();
        send_repeat();
        drain("repeat_after_reset");

        expect_valid(32'hF708FB04);
        send_frame(32'hF708FB04);
        drain("frame_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
